sd_cmd_tx: RTL and testbench

SD_CMD_TX -- requirements
Module: sd_cmd_tx

---
 rtl/sd_cmd_tx.sv | 186 ++++++++++++++++++
 tb/tb_sd_cmd_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_tx.sv
// ---------------------------------------------------------------------------
// sd_cmd_tx -- SD card CMD-line frame transmitter.
//
// Serialises a 48-bit command frame (start 0, transmission 1, 6-bit index,
// 32-bit argument, CRC7, end 1) MSB first onto the CMD line. After the end
// bit, the line is released for GAP_CYCLES cycles before the block returns
// to idle.
//
// Ports
//   sd_clk        : sole clock, rising edge
//   reset         : synchronous, active-high reset
//   send_en       : start request, honoured only while idle
//   cmd_index     : 6-bit command index, captured on an accepted request
//   cmd_arg       : 32-bit argument, captured on an accepted request
//   resp_expected : captured on an accepted request; gates receive_en
//   sd_cmd_out    : registered serial CMD data (1 while released)
//   sd_cmd_oe     : registered drive enable (1 = this block drives the line)
//   busy          : high from the start bit through the last gap cycle
//   receive_en    : one-cycle pulse on the first gap cycle (if resp_expected)
//   tx_done       : one-cycle pulse on the first idle cycle after the gap
//
// Timing note: the state register names what the line shows in the current
// cycle. Every output register is loaded with the value belonging to the
// state being entered, so the start bit is on the line in the cycle right
// after the edge that accepts send_en.
// ---------------------------------------------------------------------------
module sd_cmd_tx #(
    parameter int GAP_CYCLES = 8
) (
    input  logic        sd_clk,
    input  logic        reset,
    input  logic        send_en,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_expected,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        receive_en,
    output logic        tx_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CRC,
        ST_END,
        ST_GAP
    } state_t;

    localparam logic [5:0] HDR_LAST = 6'd39;
    localparam logic [5:0] CRC_LAST = 6'd6;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state_reg,   state_next;
    logic [39:0] hdr_reg,     hdr_next;
    logic [6:0]  crc_reg,     crc_next;
    logic [5:0]  bit_cnt_reg, bit_cnt_next;
    logic [3:0]  gap_cnt_reg, gap_cnt_next;
    logic        resp_reg,    resp_next;
    logic        out_reg,     out_next;
    logic        oe_reg,      oe_next;
    logic        busy_reg,    busy_next;
    logic        rx_reg,      rx_next;
    logic        done_reg,    done_next;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_comb begin
        state_next   = state_reg;
        hdr_next     = hdr_reg;
        crc_next     = crc_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        resp_next    = resp_reg;
        out_next     = 1'b1;
        oe_next      = 1'b0;
        busy_next    = 1'b0;
        rx_next      = 1'b0;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (send_en) begin
                    state_next   = ST_SHIFT;
                    // Start bit goes out now; the register keeps the remaining
                    // 39 header bits left-aligned for MSB-first shifting.
                    hdr_next     = {1'b1, cmd_index, cmd_arg, 1'b0};
                    crc_next     = 7'h00;  // CRC of the 0 start bit is still 0
                    bit_cnt_next = 6'd0;
                    resp_next    = resp_expected;
                    out_next     = 1'b0;
                    oe_next      = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            ST_SHIFT: begin
                oe_next   = 1'b1;
                busy_next = 1'b1;
                if (bit_cnt_reg == HDR_LAST) begin
                    // crc_reg now covers all 40 header bits.
                    state_next   = ST_CRC;
                    bit_cnt_next = 6'd0;
                    out_next     = crc_reg[6];
                    crc_next     = {crc_reg[5:0], 1'b0};
                end else begin
                    out_next     = hdr_reg[39];
                    hdr_next     = {hdr_reg[38:0], 1'b0};
                    crc_next     = crc7_step(crc_reg, hdr_reg[39]);
                    bit_cnt_next = bit_cnt_reg + 6'd1;
                end
            end
            ST_CRC: begin
                oe_next   = 1'b1;
                busy_next = 1'b1;
                if (bit_cnt_reg == CRC_LAST) begin
                    state_next   = ST_END;
                    bit_cnt_next = 6'd0;
                    out_next     = 1'b1;
                end else begin
                    out_next     = crc_reg[6];
                    crc_next     = {crc_reg[5:0], 1'b0};
                    bit_cnt_next = bit_cnt_reg + 6'd1;
                end
            end
            ST_END: begin
                state_next   = ST_GAP;
                gap_cnt_next = 4'd0;
                busy_next    = 1'b1;
                rx_next      = resp_reg;
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    busy_next    = 1'b1;
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            hdr_reg     <= '0;
            crc_reg     <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            resp_reg    <= 1'b0;
            out_reg     <= 1'b1;
            oe_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            rx_reg      <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hdr_reg     <= hdr_next;
            crc_reg     <= crc_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            resp_reg    <= resp_next;
            out_reg     <= out_next;
            oe_reg      <= oe_next;
            busy_reg    <= busy_next;
            rx_reg      <= rx_next;
            done_reg    <= done_next;
        end
    end

    assign sd_cmd_out = out_reg;
    assign sd_cmd_oe  = oe_reg;
    assign busy       = busy_reg;
    assign receive_en = rx_reg;
    assign tx_done    = done_reg;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_tx -- directed self-checking bench for sd_cmd_tx.
//
// Cycle k of a capture is the clock period that ends with edge N+k, where
// edge N is the edge that samples send_en; outputs are sampled on the
// falling edge inside that period.
// ---------------------------------------------------------------------------
module tb_sd_cmd_tx;

    logic        sd_clk = 1'b0;
    logic        reset;
    logic        send_en;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_expected;
    logic        sd_cmd_out;
    logic        sd_cmd_oe;
    logic        busy;
    logic        receive_en;
    logic        tx_done;

    int checks = 0;
    int fails  = 0;

    // Capture storage, index = cycle number after edge N.
    logic cap_out  [0:140];
    logic cap_oe   [0:140];
    logic cap_busy [0:140];
    logic cap_rx   [0:140];
    logic cap_done [0:140];

    // Summaries over cycles 1..60.
    logic [47:0] line_word;
    int oe_cnt, oe_first, oe_last, busy_cnt;
    int rx_cnt, rx_cyc, done_cnt, done_cyc;
    logic busy_at_done, gap_line_high;

    sd_cmd_tx #(.GAP_CYCLES(8)) dut (
        .sd_clk        (sd_clk),
        .reset         (reset),
        .send_en       (send_en),
        .cmd_index     (cmd_index),
        .cmd_arg       (cmd_arg),
        .resp_expected (resp_expected),
        .sd_cmd_out    (sd_cmd_out),
        .sd_cmd_oe     (sd_cmd_oe),
        .busy          (busy),
        .receive_en    (receive_en),
        .tx_done       (tx_done)
    );

    always #5 sd_clk = ~sd_clk;

    // Launch one request and record ncyc cycles of outputs.
    //   hold_until : 0 = drop send_en right after edge N, else drop at cycle k
    //   repulse_at : >0 = re-assert send_en with different inputs at cycle k
    //   reset_at   : >0 = assert reset for one edge at cycle k
    task automatic launch_and_capture(input logic [5:0] idx, input logic [31:0] arg,
                                      input logic resp, input int hold_until,
                                      input int repulse_at, input int reset_at,
                                      input int ncyc);
        @(negedge sd_clk);
        send_en       = 1'b1;
        cmd_index     = idx;
        cmd_arg       = arg;
        resp_expected = resp;
        @(posedge sd_clk);
        #1;
        if (hold_until == 0) send_en = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge sd_clk);
            cap_out[k]  = sd_cmd_out;
            cap_oe[k]   = sd_cmd_oe;
            cap_busy[k] = busy;
            cap_rx[k]   = receive_en;
            cap_done[k] = tx_done;
            if (hold_until > 0 && k == hold_until) send_en = 1'b0;
            if (repulse_at > 0 && k == repulse_at) begin
                send_en       = 1'b1;
                cmd_index     = ~idx;
                cmd_arg       = ~arg;
                resp_expected = ~resp;
            end else if (repulse_at > 0 && k == repulse_at + 1) begin
                send_en = 1'b0;
            end
            if (reset_at > 0 && k == reset_at) reset = 1'b1;
            else if (reset_at > 0 && k == reset_at + 1) reset = 1'b0;
        end
        send_en = 1'b0;
        line_word = '0;
        for (int k = 1; k <= 48; k++) line_word[48-k] = cap_out[k];
        oe_cnt = 0; oe_first = 0; oe_last = 0; busy_cnt = 0;
        rx_cnt = 0; rx_cyc = 0; done_cnt = 0; done_cyc = 0;
        busy_at_done = 1'b0; gap_line_high = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (cap_oe[k] === 1'b1) begin
                oe_cnt++;
                if (oe_first == 0) oe_first = k;
                oe_last = k;
            end
            if (cap_busy[k] === 1'b1) busy_cnt++;
            if (cap_rx[k] === 1'b1) begin
                rx_cnt++;
                if (rx_cyc == 0) rx_cyc = k;
            end
            if (cap_done[k] === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = k;
                    busy_at_done = cap_busy[k];
                end
            end
        end
        for (int k = 49; k <= 56; k++)
            if (cap_out[k] !== 1'b1 || cap_oe[k] !== 1'b0) gap_line_high = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; send_en = 1'b1;
        cmd_index = 6'd0; cmd_arg = 32'd0; resp_expected = 1'b1;
        repeat (3) @(posedge sd_clk);
        @(negedge sd_clk);
        checks++;
        if (sd_cmd_out !== 1'b1) begin fails++; $display("FAIL reset_out: got %b want 1", sd_cmd_out); end
        checks++;
        if (sd_cmd_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", sd_cmd_oe); end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_priority_busy: got %b want 0", busy); end
        checks++;
        if (receive_en !== 1'b0 || tx_done !== 1'b0) begin
            fails++; $display("FAIL reset_pulses: rx=%b done=%b want 0 0", receive_en, tx_done);
        end
        send_en = 1'b0;
        @(negedge sd_clk);
        reset = 1'b0;
        repeat (2) @(negedge sd_clk);
        checks++;
        if (busy !== 1'b0 || sd_cmd_oe !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset: busy=%b oe=%b want 0 0", busy, sd_cmd_oe);
        end
        $display("test_reset done");
    endtask

    task automatic test_cmd0;
        launch_and_capture(6'd0, 32'h0000_0000, 1'b0, 0, 0, 0, 64);
        checks++;
        if (line_word !== 48'h4000_0000_0095) begin
            fails++; $display("FAIL cmd0_line: got %h want 400000000095", line_word);
        end
        checks++;
        if (rx_cnt !== 0) begin fails++; $display("FAIL cmd0_no_rx: got %0d pulses want 0", rx_cnt); end
        checks++;
        if (done_cyc !== 57 || done_cnt !== 1) begin
            fails++; $display("FAIL cmd0_done: got cycle %0d count %0d want 57 1", done_cyc, done_cnt);
        end
        checks++;
        if (gap_line_high !== 1'b1) begin fails++; $display("FAIL cmd0_gap_release: got %b want 1", gap_line_high); end
        $display("test_cmd0 line=%h rx=%0d done@%0d", line_word, rx_cnt, done_cyc);
    endtask

    task automatic test_cmd8;
        launch_and_capture(6'd8, 32'h0000_01AA, 1'b1, 0, 0, 0, 64);
        checks++;
        if (line_word !== 48'h4800_0001_AA87) begin
            fails++; $display("FAIL cmd8_line: got %h want 48000001AA87", line_word);
        end
        checks++;
        if (rx_cyc !== 49 || rx_cnt !== 1) begin
            fails++; $display("FAIL cmd8_rx: got cycle %0d count %0d want 49 1", rx_cyc, rx_cnt);
        end
        checks++;
        if (done_cyc !== 57 || done_cnt !== 1) begin
            fails++; $display("FAIL cmd8_done: got cycle %0d count %0d want 57 1", done_cyc, done_cnt);
        end
        $display("test_cmd8 line=%h rx@%0d done@%0d", line_word, rx_cyc, done_cyc);
    endtask

    task automatic test_cmd17;
        launch_and_capture(6'd17, 32'h0000_0000, 1'b0, 0, 0, 0, 64);
        checks++;
        if (line_word !== 48'h5100_0000_0055) begin
            fails++; $display("FAIL cmd17_line: got %h want 510000000055", line_word);
        end
        checks++;
        if (oe_cnt !== 48 || oe_first !== 1 || oe_last !== 48) begin
            fails++; $display("FAIL cmd17_oe: got count %0d span %0d..%0d want 48 1..48", oe_cnt, oe_first, oe_last);
        end
        checks++;
        if (busy_cnt !== 56 || cap_busy[56] !== 1'b1) begin
            fails++; $display("FAIL cmd17_busy: got count %0d want 56", busy_cnt);
        end
        checks++;
        if (busy_at_done !== 1'b0) begin fails++; $display("FAIL cmd17_busy_at_done: got %b want 0", busy_at_done); end
        $display("test_cmd17 line=%h oe=%0d busy=%0d", line_word, oe_cnt, busy_cnt);
    endtask

    task automatic test_ignore_busy;
        launch_and_capture(6'd8, 32'h0000_01AA, 1'b1, 0, 10, 0, 64);
        checks++;
        if (line_word !== 48'h4800_0001_AA87) begin
            fails++; $display("FAIL busy_line: got %h want 48000001AA87", line_word);
        end
        checks++;
        if (rx_cyc !== 49 || rx_cnt !== 1) begin
            fails++; $display("FAIL busy_rx: got cycle %0d count %0d want 49 1", rx_cyc, rx_cnt);
        end
        checks++;
        if (busy_cnt !== 56 || done_cnt !== 1 || cap_oe[60] !== 1'b0) begin
            fails++; $display("FAIL busy_no_queue: got busy %0d done %0d oe60 %b want 56 1 0", busy_cnt, done_cnt, cap_oe[60]);
        end
        $display("test_ignore_busy line=%h busy=%0d", line_word, busy_cnt);
    endtask

    task automatic test_back_to_back;
        logic [47:0] second_word;
        launch_and_capture(6'd0, 32'h0000_0000, 1'b0, 60, 0, 0, 130);
        second_word = '0;
        for (int k = 58; k <= 105; k++) second_word[105-k] = cap_out[k];
        checks++;
        if (cap_done[57] !== 1'b1 || cap_oe[57] !== 1'b0) begin
            fails++; $display("FAIL b2b_done57: got done %b oe %b want 1 0", cap_done[57], cap_oe[57]);
        end
        checks++;
        if (cap_out[58] !== 1'b0 || cap_oe[58] !== 1'b1) begin
            fails++; $display("FAIL b2b_start58: got out %b oe %b want 0 1", cap_out[58], cap_oe[58]);
        end
        checks++;
        if (second_word !== 48'h4000_0000_0095) begin
            fails++; $display("FAIL b2b_second_line: got %h want 400000000095", second_word);
        end
        checks++;
        if (cap_done[114] !== 1'b1 || cap_done[113] !== 1'b0) begin
            fails++; $display("FAIL b2b_done114: got %b%b want 01", cap_done[113], cap_done[114]);
        end
        $display("test_back_to_back second=%h", second_word);
    endtask

    task automatic test_reset_mid;
        logic idle_ok;
        launch_and_capture(6'd8, 32'h0000_01AA, 1'b1, 0, 0, 20, 64);
        idle_ok = 1'b1;
        for (int k = 21; k <= 64; k++)
            if (cap_oe[k] !== 1'b0 || cap_out[k] !== 1'b1 || cap_busy[k] !== 1'b0) idle_ok = 1'b0;
        checks++;
        if (cap_oe[20] !== 1'b1 || cap_busy[20] !== 1'b1) begin
            fails++; $display("FAIL rstmid_active20: got oe %b busy %b want 1 1", cap_oe[20], cap_busy[20]);
        end
        checks++;
        if (idle_ok !== 1'b1) begin fails++; $display("FAIL rstmid_released: got %b want 1", idle_ok); end
        checks++;
        if (rx_cnt !== 0 || done_cnt !== 0) begin
            fails++; $display("FAIL rstmid_pulses: got rx %0d done %0d want 0 0", rx_cnt, done_cnt);
        end
        launch_and_capture(6'd17, 32'h0000_0000, 1'b1, 0, 0, 0, 64);
        checks++;
        if (line_word !== 48'h5100_0000_0055 || done_cyc !== 57 || rx_cyc !== 49) begin
            fails++; $display("FAIL rstmid_next_frame: got %h done %0d rx %0d want 510000000055 57 49", line_word, done_cyc, rx_cyc);
        end
        $display("test_reset_mid next=%h", line_word);
    endtask

    initial begin
        test_reset;
        test_cmd0;
        test_cmd8;
        test_cmd17;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
